// File: rtl/icache_pkg.sv
// Shared FSM type, default geometry and address-split helpers for the instruction cache.
package icache_pkg;

  localparam int unsigned DefaultSets      = 64;
  localparam int unsigned DefaultLineWords = 4;
  localparam int unsigned OFFB             = $clog2(DefaultLineWords);
  localparam int unsigned IDXB             = $clog2(DefaultSets);
  localparam int unsigned TAGB             = 32 - 2 - OFFB - IDXB;

  typedef enum logic [1:0] {StIdle, StReq, StFill} icache_state_t;

  function automatic logic [31:0] addr_off(input logic [31:0] addr, input int unsigned offb);
    return (addr >> 2) & ((32'd1 << offb) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int unsigned offb,
                                           input int unsigned idxb);
    return (addr >> (2 + offb)) & ((32'd1 << idxb) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned offb,
                                           input int unsigned idxb);
    return addr >> (2 + offb + idxb);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational tag/valid lookup, registered data read, line-fill writes.
module icache_array #(
  parameter int unsigned IdxB = icache_pkg::IDXB,
  parameter int unsigned OffB = icache_pkg::OFFB,
  parameter int unsigned TagB = icache_pkg::TAGB
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IdxB-1:0] rd_idx_i,
  input  logic [OffB-1:0] rd_off_i,
  output logic            rd_valid_o,
  output logic [TagB-1:0] rd_tag_o,
  output logic [31:0]     rd_data_o,
  input  logic            wr_en_i,
  input  logic [IdxB-1:0] wr_idx_i,
  input  logic [OffB-1:0] wr_off_i,
  input  logic [31:0]     wr_data_i,
  input  logic            line_done_i,
  input  logic [TagB-1:0] wr_tag_i,
  input  logic            clr_en_i,
  input  logic [IdxB-1:0] clr_idx_i,
  input  logic            inv_all_i
);

  localparam int unsigned Sets  = 2 ** IdxB;
  localparam int unsigned Words = 2 ** (IdxB + OffB);

  logic [Sets-1:0] valid_q, valid_d;
  logic [TagB-1:0] tag_mem  [Sets];
  logic [31:0]     data_mem [Words];
  logic [31:0]     rd_data_q;

  // Bulk invalidate overrides a line completing in the same cycle.
  always_comb begin
    valid_d = valid_q;
    if (clr_en_i)    valid_d[clr_idx_i] = 1'b0;
    if (line_done_i) valid_d[wr_idx_i]  = 1'b1;
    if (inv_all_i)   valid_d            = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (line_done_i) tag_mem[wr_idx_i] <= wr_tag_i;
    if (wr_en_i)     data_mem[{wr_idx_i, wr_off_i}] <= wr_data_i;
    rd_data_q <= data_mem[{rd_idx_i, rd_off_i}];
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/icache_resp.sv
// Direct-mapped read-only instruction cache responder with one outstanding fill.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_resp
  import icache_pkg::*;
#(
  parameter int unsigned SETS       = icache_pkg::DefaultSets,
  parameter int unsigned LINE_WORDS = icache_pkg::DefaultLineWords,
  parameter logic [31:0] CODE_BASE  = 32'h0000_0000,
  parameter logic [31:0] CODE_LIMIT = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  input  logic        inv,
  output logic [31:0] i_data,
  output logic        i_miss,
  output logic        i_segfault,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_vld
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned OffB = $clog2(LINE_WORDS);
  localparam int unsigned IdxB = $clog2(SETS);
  localparam int unsigned TagB = 32 - 2 - OffB - IdxB;

  icache_state_t state_q, state_d;
  logic [TagB-1:0] fill_tag_q, fill_tag_d;
  logic [IdxB-1:0] fill_idx_q, fill_idx_d;
  logic [OffB-1:0] cnt_q, cnt_d;
  logic            rd_q, rd_d, hit_q, hit_d, miss_q, miss_d, seg_q, seg_d;
  logic [31:0]     data_hold_q, data_hold_d;

  logic [OffB-1:0] req_off;
  logic [IdxB-1:0] req_idx;
  logic [TagB-1:0] req_tag;
  logic            seg, hit, miss, launch;
  logic            arr_valid, wr_en, line_done, clr_en;
  logic [TagB-1:0] arr_tag;
  logic [31:0]     arr_rdata;

  assign req_off = OffB'(addr_off(i_addr, OffB));
  assign req_idx = IdxB'(addr_idx(i_addr, OffB, IdxB));
  assign req_tag = TagB'(addr_tag(i_addr, OffB, IdxB));

  // A single unsigned compare covers both bounds: addresses below the base wrap high.
  assign seg    = (|i_addr[1:0]) || ((i_addr - CODE_BASE) > (CODE_LIMIT - CODE_BASE));
  assign hit    = i_rd && !seg && !inv && arr_valid && (arr_tag == req_tag);
  assign miss   = i_rd && !seg && !hit;
  assign launch = miss && !inv && (state_q == StIdle);

  icache_array #(
    .IdxB (IdxB),
    .OffB (OffB),
    .TagB (TagB)
  ) u_array (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_idx_i    (req_idx),
    .rd_off_i    (req_off),
    .rd_valid_o  (arr_valid),
    .rd_tag_o    (arr_tag),
    .rd_data_o   (arr_rdata),
    .wr_en_i     (wr_en),
    .wr_idx_i    (fill_idx_q),
    .wr_off_i    (cnt_q),
    .wr_data_i   (mem_data),
    .line_done_i (line_done),
    .wr_tag_i    (fill_tag_q),
    .clr_en_i    (clr_en),
    .clr_idx_i   (req_idx),
    .inv_all_i   (inv)
  );

  always_comb begin
    state_d    = state_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    line_done  = 1'b0;
    clr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          fill_tag_d = req_tag;
          fill_idx_d = req_idx;
          clr_en     = 1'b1;
          cnt_d      = '0;
          state_d    = StReq;
        end
      end
      StReq: state_d = StFill;
      StFill: begin
        if (mem_vld) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + OffB'(1);
          if (cnt_q == OffB'(LINE_WORDS - 1)) begin
            line_done = 1'b1;
            cnt_d     = '0;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (inv) begin
      state_d   = StIdle;
      cnt_d     = '0;
      wr_en     = 1'b0;
      line_done = 1'b0;
    end
  end

  always_comb begin
    rd_d        = i_rd;
    hit_d       = hit;
    miss_d      = miss;
    seg_d       = i_rd && seg;
    data_hold_d = i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      fill_tag_q  <= '0;
      fill_idx_q  <= '0;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      seg_q       <= 1'b0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_tag_q  <= fill_tag_d;
      fill_idx_q  <= fill_idx_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      seg_q       <= seg_d;
      data_hold_q <= data_hold_d;
    end
  end

  // Idle cycles repeat the previous word; misses and segfaults return zero.
  assign i_data     = hit_q ? arr_rdata : (rd_q ? 32'd0 : data_hold_q);
  assign i_miss     = miss_q;
  assign i_segfault = seg_q;
  assign mem_rd     = (state_q == StReq);
  assign mem_addr   = {fill_tag_q, fill_idx_q, {(OffB + 2){1'b0}}};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Self-checking bench for icache_resp: expected responses queued at request time, popped a cycle later.
module tb_icache_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_rd = 1'b0;
  logic        inv = 1'b0;
  logic [31:0] i_data;
  logic        i_miss, i_segfault, mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_vld = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_resp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_addr     (i_addr),
    .i_rd       (i_rd),
    .inv        (inv),
    .i_data     (i_data),
    .i_miss     (i_miss),
    .i_segfault (i_segfault),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_vld    (mem_vld)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  typedef struct packed {
    logic        miss;
    logic        seg;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   p0;

  always @(posedge clk) if (mem_rd) pulses <= pulses + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic m, input logic s, input logic [31:0] d);
    i_addr = a;
    i_rd   = 1'b1;
    sb.push_back(exp_t'({m, s, d}));
  endtask

  task automatic feed(input logic [31:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      mem_data = first + 32'(k);
      mem_vld  = 1'b1;
      tick();
    end
    mem_vld = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({i_miss, i_segfault, i_data} !== 34'd0) begin
      errors++;
      $display("FAIL reset_rsp: got %h want 0", {i_miss, i_segfault, i_data});
    end
    checks++;
    if ({mem_rd, mem_addr} !== 33'd0) begin
      errors++;
      $display("FAIL reset_mem: got %h want 0", {mem_rd, mem_addr});
    end
  endtask

  task automatic test_cold_miss();
    p0 = pulses;
    req(32'h100, 1'b1, 1'b0, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL cold_miss: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL cold_req: got %h want %h", {mem_rd, mem_addr}, {1'b1, 32'h100});
    end
    tick();
    feed(32'hA0, 4);
    checks++;
    if (pulses - p0 !== 1) begin
      errors++; $display("FAIL cold_pulses: got %0d want 1", pulses - p0);
    end
    req(32'h104, 1'b0, 1'b0, 32'hA1);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL cold_hit: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    tick(); checks++;
    if ({i_miss, i_segfault, i_data} !== {2'b00, 32'hA1}) begin
      errors++; $display("FAIL idle_hold: got %h want %h", {i_miss, i_segfault, i_data},
                         {2'b00, 32'hA1});
    end
  endtask

  task automatic test_hit_under_miss();
    p0 = pulses;
    req(32'h200, 1'b1, 1'b0, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL hum_miss: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    tick();
    req(32'h108, 1'b0, 1'b0, 32'hA2);
    mem_data = 32'hB0; mem_vld = 1'b1;
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL hum_hit: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    req(32'h300, 1'b1, 1'b0, 32'h0);
    mem_data = 32'hB1;
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL hum_busy_miss: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    feed(32'hB2, 2);
    tick(); checks++;
    if (pulses - p0 !== 1) begin
      errors++; $display("FAIL hum_pulses: got %0d want 1", pulses - p0);
    end
    req(32'h204, 1'b0, 1'b0, 32'hB1);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL hum_new_line: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
  endtask

  task automatic test_segfault();
    p0 = pulses;
    req(32'h102, 1'b0, 1'b1, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL seg_align: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    req(32'h1_0000, 1'b0, 1'b1, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL seg_limit: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    tick(); tick(); checks++;
    if (pulses - p0 !== 0) begin
      errors++; $display("FAIL seg_no_fill: got %0d want 0", pulses - p0);
    end
    req(32'hFFFC, 1'b1, 1'b0, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL top_word_miss: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 32'hFFF0}) begin
      errors++; $display("FAIL top_word_req: got %h want %h", {mem_rd, mem_addr},
                         {1'b1, 32'hFFF0});
    end
    tick();
    feed(32'h10, 4);
    req(32'hFFFC, 1'b0, 1'b0, 32'h13);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL top_word_hit: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
  endtask

  task automatic test_inv_mid_fill();
    req(32'h700, 1'b1, 1'b0, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL inv_launch: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    tick();
    feed(32'h70, 2);
    inv = 1'b1;
    req(32'h204, 1'b1, 1'b0, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL inv_same_cycle: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    inv = 1'b0; i_rd = 1'b0;
    p0 = pulses;
    feed(32'h72, 2);
    tick(); checks++;
    if (pulses - p0 !== 0) begin
      errors++; $display("FAIL inv_no_fill: got %0d want 0", pulses - p0);
    end
    req(32'h200, 1'b1, 1'b0, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL inv_refetch: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL inv_refetch_req: got %h want %h", {mem_rd, mem_addr},
                         {1'b1, 32'h200});
    end
    tick();
    feed(32'hC0, 4);
    req(32'h20C, 1'b0, 1'b0, 32'hC3);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL inv_refill_hit: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
  endtask

  task automatic test_conflict();
    req(32'h100, 1'b1, 1'b0, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL conf_miss_a: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    tick();
    feed(32'hD0, 4);
    req(32'h100, 1'b0, 1'b0, 32'hD0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL conf_hit_a: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    req(32'h500, 1'b1, 1'b0, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL conf_miss_b: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    tick();
    feed(32'hE0, 3);
    req(32'h500, 1'b1, 1'b0, 32'h0);
    mem_data = 32'hE3; mem_vld = 1'b1;
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL conf_fill_edge: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    mem_vld = 1'b0;
    req(32'h500, 1'b0, 1'b0, 32'hE0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL conf_hit_b: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    req(32'h100, 1'b1, 1'b0, 32'h0);
    tick(); e = sb.pop_front(); checks++;
    if ({i_miss, i_segfault, i_data} !== e) begin
      errors++; $display("FAIL conf_evicted: got %h want %h", {i_miss, i_segfault, i_data}, e);
    end
    i_rd = 1'b0;
    tick();
    feed(32'hF0, 4);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    logic [31:0] h0, m0;
    h0 = hit_cnt; m0 = miss_cnt;
    i_rd = 1'b1;
    i_addr = 32'h100; tick();
    i_addr = 32'h104; tick();
    i_addr = 32'h208; tick();
    i_addr = 32'h900; tick();
    i_addr = 32'hA00; tick();
    i_addr = 32'h003; tick();
    i_rd = 1'b0;
    checks++;
    if (hit_cnt - h0 !== 32'd3) begin
      errors++; $display("FAIL stats_hits: got %0d want 3", hit_cnt - h0);
    end
    checks++;
    if (miss_cnt - m0 !== 32'd2) begin
      errors++; $display("FAIL stats_misses: got %0d want 2", miss_cnt - m0);
    end
    feed(32'h90, 4);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    test_reset();
    test_cold_miss();
    test_hit_under_miss();
    test_segfault();
    test_inv_mid_fill();
    test_conflict();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
